// File: rtl/space_wire_pkg.sv
// Shared types and widths for the SpaceWire time-code master.
package space_wire_pkg;

  localparam int unsigned TIME_W  = 6;
  localparam int unsigned FLAGS_W = 2;
  localparam int unsigned CODE_W  = FLAGS_W + TIME_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  typedef struct packed {
    logic [FLAGS_W-1:0] flags;
    logic [TIME_W-1:0]  tval;
  } time_code_t;

  // Time counter advance; wraps 63 -> 0 through the 6-bit result.
  function automatic logic [TIME_W-1:0] time_inc(input logic [TIME_W-1:0] t);
    return t + TIME_W'(1);
  endfunction

endpackage

// File: rtl/space_wire_time_master_if.sv
// Time-code handshake between the time master and the link transmitter.
interface space_wire_time_master_if;

  logic                              o_tx_req;
  logic [space_wire_pkg::CODE_W-1:0] o_tx_time_code;
  logic                              i_tx_ready;
  logic                              i_tx_ack;

  modport master (
    output o_tx_req,
    output o_tx_time_code,
    input  i_tx_ready,
    input  i_tx_ack
  );

  modport slave (
    input  o_tx_req,
    input  o_tx_time_code,
    output i_tx_ready,
    output i_tx_ack
  );

endinterface

// File: rtl/space_wire_period_timer.sv
// Down-counter producing a one-cycle expire pulse every i_period clocks.
module space_wire_period_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic                i_restart,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_expire_c
);

  logic [PERIOD_W-1:0] count_q;
  logic [PERIOD_W-1:0] count_d;

  // A zero period never expires; the restart cycle only reloads.
  assign o_expire_c = i_enable && !i_restart && (i_period != '0) && (count_q == '0);

  always_comb begin
    count_d = count_q - PERIOD_W'(1);
    if (!i_enable || i_restart || o_expire_c) begin
      count_d = i_period - PERIOD_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/space_wire_time_master.sv
// SpaceWire time master: counts tick events and hands time codes to the transmitter.
module space_wire_time_master
  import space_wire_pkg::*;
#(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  input  logic [PERIOD_W-1:0]       i_period,
  input  logic                      i_tick_in,
  input  logic [FLAGS_W-1:0]        i_ctrl_flags,
  input  logic                      i_load,
  input  logic [TIME_W-1:0]         i_load_value,
  space_wire_time_master_if.master  tx,
  output logic [TIME_W-1:0]         o_time_value,
  output logic                      o_busy,
  output logic                      o_overrun
);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  time_code_t        code_q, code_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              en_q, en_d;

  logic              expire_c;
  logic              restart_c;
  logic              tick_c;
  logic [TIME_W-1:0] next_time_c;

  // Timer reloads on the first enabled cycle so it never expires straight out of reset.
  assign restart_c   = i_enable && !en_q;
  assign tick_c      = i_enable && (i_tick_in || expire_c);
  assign next_time_c = time_inc(i_load ? i_load_value : time_q);

  space_wire_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_period_timer (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_enable   (i_enable),
    .i_restart  (restart_c),
    .i_period   (i_period),
    .o_expire_c (expire_c)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (tick_c)        state_d = tx.i_tx_ready ? ST_SEND : ST_PEND;
      ST_PEND: if (tx.i_tx_ready) state_d = ST_SEND;
      ST_SEND: if (tx.i_tx_ack)   state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
    if (!i_enable) begin
      state_d = ST_IDLE;
    end
  end

  // Ticks outside IDLE are dropped; a lone load never touches a latched code.
  always_comb begin
    time_d    = time_q;
    code_d    = code_q;
    req_d     = (state_d == ST_SEND);
    busy_d    = (state_d != ST_IDLE);
    overrun_d = tick_c && (state_q != ST_IDLE);
    en_d      = i_enable;
    if (tick_c && (state_q == ST_IDLE)) begin
      time_d      = next_time_c;
      code_d.flags = i_ctrl_flags;
      code_d.tval  = next_time_c;
    end else if (i_load) begin
      time_d = i_load_value;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      time_q    <= '0;
      code_q    <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      time_q    <= time_d;
      code_q    <= code_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      en_q      <= en_d;
    end
  end

  assign tx.o_tx_req       = req_q;
  assign tx.o_tx_time_code = code_q;
  assign o_time_value      = time_q;
  assign o_busy            = busy_q;
  assign o_overrun         = overrun_q;

endmodule

// File: tb/tb_space_wire_time_master.sv
// Bench for space_wire_time_master: directed scenarios plus random traffic against a transaction model.
module tb_space_wire_time_master;

  localparam int unsigned PW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] period = '0;
  logic          tick_in = 1'b0;
  logic [1:0]    flags = 2'b00;
  logic          load = 1'b0;
  logic [5:0]    load_value = 6'd0;
  logic          ready = 1'b0;
  logic          ack = 1'b0;
  logic [5:0]    time_value;
  logic          busy;
  logic          overrun;

  space_wire_time_master_if tx_if ();
  assign tx_if.i_tx_ready = ready;
  assign tx_if.i_tx_ack   = ack;

  space_wire_time_master #(.PERIOD_W(PW)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_enable     (enable),
    .i_period     (period),
    .i_tick_in    (tick_in),
    .i_ctrl_flags (flags),
    .i_load       (load),
    .i_load_value (load_value),
    .tx           (tx_if),
    .o_time_value (time_value),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Model: a code is "outstanding" from its tick until acked; "offered" once ready was seen.
  typedef struct {
    bit         outstanding;
    bit         offered;
    int         phase;
    bit         en_prev;
    logic [5:0] tv;
    logic [7:0] code;
    bit         ovr;
  } model_t;

  model_t m;

  function automatic model_t model_zero();
    model_t z;
    z.outstanding = 0; z.offered = 0; z.phase = 0; z.en_prev = 0;
    z.tv = 6'd0; z.code = 8'd0; z.ovr = 0;
    return z;
  endfunction

  function automatic model_t model_next(model_t c, bit en, int per, bit tin, bit ld,
                                        int lv, int fl, bit rdy, bit ak);
    model_t n = c;
    bit expire = 0;
    bit tick;
    int base;
    n.ovr = 0;
    n.en_prev = en;
    if (!en || !c.en_prev) n.phase = 0;
    else begin
      n.phase = c.phase + 1;
      if (per != 0 && n.phase == per) begin expire = 1; n.phase = 0; end
    end
    tick = en && (tin || expire);
    if (tick && c.outstanding) n.ovr = 1;
    if (tick && !c.outstanding) begin
      base = ld ? lv : int'(c.tv);
      n.tv = 6'((base + 1) % 64);
      n.code = 8'(fl * 64 + int'(n.tv));
      n.outstanding = 1;
      n.offered = rdy;
    end else begin
      if (ld) n.tv = 6'(lv);
      if (c.outstanding) begin
        if (c.offered) begin
          if (ak) begin n.outstanding = 0; n.offered = 0; end
        end else if (rdy) n.offered = 1;
      end
    end
    if (!en) begin n.outstanding = 0; n.offered = 0; end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_zero();
    else m <= model_next(m, enable, int'(period), tick_in, load, int'(load_value),
                         int'(flags), ready, ack);
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ack_delay = -1;
  int req_age = 0;
  int rise_cnt = 0;
  int ovr_cnt = 0;
  bit req_prev = 0;
  logic [7:0] rise_code [0:7];
  int rise_cyc [0:7];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // One clock: compare against the model, log handshake events, drive ack.
  task automatic step();
    @(negedge clk);
    cyc++;
    chk("model_req", 32'(tx_if.o_tx_req), 32'(m.offered));
    chk("model_code", 32'(tx_if.o_tx_time_code), 32'(m.code));
    chk("model_time", 32'(time_value), 32'(m.tv));
    chk("model_busy", 32'(busy), 32'(m.outstanding));
    chk("model_overrun", 32'(overrun), 32'(m.ovr));
    if (tx_if.o_tx_req && !req_prev) begin
      if (rise_cnt < 8) begin
        rise_code[rise_cnt] = tx_if.o_tx_time_code;
        rise_cyc[rise_cnt]  = cyc;
      end
      rise_cnt++;
    end
    req_prev = tx_if.o_tx_req;
    if (overrun) ovr_cnt++;
    if (tx_if.o_tx_req) begin
      ack = (ack_delay < 0) ? ($urandom % 3 == 0) : (req_age == ack_delay);
      req_age++;
    end else begin
      ack = (ack_delay < 0) ? ($urandom % 3 == 0) : 1'b0;
      req_age = 0;
    end
  endtask

  task automatic apply_reset();
    enable = 0; tick_in = 0; load = 0; ready = 0; flags = 2'b00; period = '0;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    rise_cnt = 0;
    ovr_cnt = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    apply_reset();
    chk("reset_req", 32'(tx_if.o_tx_req), 32'd0);
    chk("reset_code", 32'(tx_if.o_tx_time_code), 32'h00);
    chk("reset_time", 32'(time_value), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Periodic ticks, ack two cycles after each request.
    ack_delay = 2; ready = 1; period = PW'(10); enable = 1;
    for (int i = 0; i < 35; i++) step();
    chk("per_rises", 32'(rise_cnt), 32'd3);
    chk("per_code0", 32'(rise_code[0]), 32'h01);
    chk("per_code1", 32'(rise_code[1]), 32'h02);
    chk("per_code2", 32'(rise_code[2]), 32'h03);
    chk("per_gap0", 32'(rise_cyc[1] - rise_cyc[0]), 32'd10);
    chk("per_gap1", 32'(rise_cyc[2] - rise_cyc[1]), 32'd10);
    chk("per_overrun", 32'(ovr_cnt), 32'd0);

    // Load 63 then tick with flags 10: wraps to zero.
    enable = 0; step(); step();
    period = '0; enable = 1; ack_delay = 0; step();
    load = 1; load_value = 6'd63; step(); load = 0;
    chk("load_time", 32'(time_value), 32'd63);
    tick_in = 1; flags = 2'b10; step(); tick_in = 0; flags = 2'b00;
    chk("wrap_code", 32'(tx_if.o_tx_time_code), 32'h80);
    chk("wrap_time", 32'(time_value), 32'd0);
    chk("wrap_req", 32'(tx_if.o_tx_req), 32'd1);
    step(); step();

    // Tick while transmitter not ready: pending for five cycles.
    apply_reset();
    ack_delay = 0; enable = 1; ready = 0; tick_in = 1; step(); tick_in = 0;
    for (int i = 0; i < 5; i++) begin
      chk("pend_busy", 32'(busy), 32'd1);
      chk("pend_noreq", 32'(tx_if.o_tx_req), 32'd0);
      if (i < 4) step();
    end
    ready = 1; step();
    chk("pend_req", 32'(tx_if.o_tx_req), 32'd1);
    chk("pend_code", 32'(tx_if.o_tx_time_code), 32'h01);
    step(); step();

    // Second tick during SEND is dropped with one overrun pulse.
    apply_reset();
    ack_delay = 5; enable = 1; ready = 1; tick_in = 1; step(); tick_in = 0;
    step(); step();
    tick_in = 1; step(); tick_in = 0;
    for (int i = 0; i < 10; i++) step();
    chk("ovr_pulses", 32'(ovr_cnt), 32'd1);
    chk("ovr_time", 32'(time_value), 32'd1);
    chk("ovr_idle", 32'(busy), 32'd0);

    // External tick coinciding with period expiry counts once.
    apply_reset();
    ack_delay = 0; ready = 1; period = PW'(4); enable = 1; step();
    step(); step(); step();
    tick_in = 1; step(); tick_in = 0;
    chk("coinc_time", 32'(time_value), 32'd1);
    step(); step(); step();
    chk("coinc_rises", 32'(rise_cnt), 32'd1);
    chk("coinc_time2", 32'(time_value), 32'd1);
    enable = 0; step();

    // Disable during SEND aborts the request but keeps the time.
    period = '0; ack_delay = 100; enable = 1; tick_in = 1; step(); tick_in = 0;
    step();
    chk("dis_req_before", 32'(tx_if.o_tx_req), 32'd1);
    enable = 0; step();
    chk("dis_req", 32'(tx_if.o_tx_req), 32'd0);
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_time", 32'(time_value), 32'd2);
    enable = 1; step(); step(); step();
    chk("reen_busy", 32'(busy), 32'd0);
    chk("reen_time", 32'(time_value), 32'd2);

    // Reset mid-SEND clears the request without waiting for a clock.
    tick_in = 1; step(); tick_in = 0;
    chk("rst_req_before", 32'(tx_if.o_tx_req), 32'd1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_req_async", 32'(tx_if.o_tx_req), 32'd0);
    chk("rst_time_async", 32'(time_value), 32'd0);
    chk("rst_busy_async", 32'(busy), 32'd0);
    apply_reset();

    // Random traffic against the model.
    ack_delay = -1; enable = 1; period = PW'(7);
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom % 64 == 0) enable = ~enable;
      if (!enable && ($urandom % 4 == 0)) period = PW'($urandom % 13);
      tick_in    = ($urandom % 8 == 0);
      load       = ($urandom % 16 == 0);
      load_value = 6'($urandom);
      flags      = 2'($urandom);
      ready      = ($urandom % 4 != 0);
    end
    tick_in = 0; load = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/space_wire_time_master.md
SPACE_WIRE_TIME_MASTER -- requirements
Module: space_wire_time_master

Interface
REQ-001 Parameter PERIOD_W, default 24, SHALL set the width of the auto-tick period input and the period counter.
REQ-002 i_clk  input  1  SHALL be the system clock; every register is clocked on its rising edge.
REQ-003 i_reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 i_enable  input  1  SHALL be the master enable; low holds the block idle.
REQ-005 i_period  input  PERIOD_W  SHALL give the clocks between auto ticks; 0 disables auto ticks.
REQ-006 i_tick_in  input  1  SHALL be a one-cycle external tick request.
REQ-007 i_ctrl_flags  input  2  SHALL supply the control flags, sampled on each tick event.
REQ-008 i_load  input  1  SHALL be a one-cycle strobe that presets the time counter.
REQ-009 i_load_value  input  6  SHALL be the preset value.
REQ-010 i_tx_ready  input  1  SHALL indicate that the link transmitter is in Run and can accept a time code.
REQ-011 i_tx_ack  input  1  SHALL be the transmitter acknowledge of o_tx_req.
REQ-012 o_tx_req  output  1  SHALL be the time-code send request.
REQ-013 o_tx_time_code  output  8  SHALL carry {flags[1:0], time[5:0]}, stable while o_tx_req is high.
REQ-014 o_time_value  output  6  SHALL be the current time counter.
REQ-015 o_busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-016 o_overrun  output  1  SHALL be a one-cycle pulse when a tick event is dropped.

Function
REQ-017 A tick event SHALL be i_tick_in=1, or the period counter expiring, in a cycle with i_enable=1; simultaneous sources SHALL count as one event.
REQ-018 Period counter: loads i_period-1 when enabled from idle or after expiry, and decrements each cycle; expiry occurs at value 0 when i_period!=0.
REQ-019 On a tick event in IDLE, the time counter SHALL become time+1 mod 64 (wrap from 63 to 0), and o_tx_time_code SHALL latch {i_ctrl_flags, time+1}.
REQ-020 If i_load and a tick event coincide, the new time SHALL be i_load_value+1 mod 64.
REQ-021 i_load alone SHALL update o_time_value the next cycle and SHALL NOT change a pending o_tx_time_code.
REQ-022 FSM states SHALL be IDLE, PEND and SEND.
  - IDLE, on a tick event: go to SEND if i_tx_ready=1, else go to PEND.
  - PEND: go to SEND on i_tx_ready=1.
  - SEND: go to IDLE on i_tx_ack=1.
REQ-023 o_tx_req SHALL be registered, high exactly in SEND; first assertion is the cycle after the tick event.
REQ-024 i_tx_ack SHALL be honoured only in SEND; an ack in the same cycle req first rises is valid.
REQ-025 A tick event in PEND or SEND SHALL be dropped: counter unchanged, o_overrun=1 the next cycle.
REQ-026 i_tx_ready falling in SEND SHALL NOT drop o_tx_req; the request is held until ack.
REQ-027 i_enable=0 SHALL force IDLE and o_tx_req=0 the next cycle, abort any pending code without incrementing again, and hold the period counter reloaded; o_time_value SHALL be retained.

Reset
REQ-028 Under reset, the following SHALL hold:
  - state = IDLE;
  - o_tx_req=0, o_tx_time_code=8'h00, o_time_value=6'd0, o_busy=0, o_overrun=0;
  - period counter = 0.
REQ-029 Reset asserted mid-SEND SHALL clear o_tx_req asynchronously.

Structure
REQ-030 The shared package space_wire_pkg SHALL hold:
  - the state encoding (IDLE/PEND/SEND);
  - TIME_W=6 and FLAGS_W=2.
REQ-031 The period counter SHALL be the sub-module space_wire_period_timer (inputs enable, period, restart; output expire pulse).

Verification
REQ-032 The bench SHALL cover these directed scenarios:
  - i_period=10, i_tx_ready=1, ack 2 cycles after req -> req every 10 clocks; codes 0x01, 0x02, 0x03; no overrun.
  - Load 63, then i_tick_in, flags=2'b10 -> o_tx_time_code=0x80, o_time_value=0.
  - i_tx_ready=0, then tick; ready raised 5 cycles later -> PEND for 5 cycles, then req with code 0x01.
  - Tick; second tick while SEND waits for ack -> o_overrun pulse once; after ack, o_time_value=1.
  - i_tick_in and period expiry in the same cycle -> single increment, single req.
  - i_enable dropped during SEND, or reset mid-SEND -> o_tx_req=0 next cycle (immediately under reset); on reset, o_time_value=0.
